viterbi_burst_channel: RTL and testbench
========================================

Name: viterbi_burst_channel

Overview:
Parametrised channel model placed between the convolutional encoder and the Viterbi decoder in the tx/rx test harness. It replaces the fixed in-line error injector with a registered, seedable block. It supports four run-time modes (clean, random single-symbol errors, fixed-length error bursts, full inversion) and any symbol width. It reports the applied error mask and keeps running bit/symbol error counts, so benches can correlate decoder output errors with injected channel errors.

Parameters:
W, 2, symbol width in bits (encoder output width); legal range 1..16
N, 6, rate exponent: an error event triggers when LFSR[N-1:0] is all ones (about 1 in 2**N symbols); legal range 1..16
BURST_LEN, 4, number of consecutive valid symbols corrupted per burst in mode 2; legal range 1..255
SEED, 32'hACE1_2B3D, LFSR value after reset; must be nonzero

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
mode_i  input  2  0=clean, 1=random single, 2=burst, 3=invert all; sampled on each valid_i cycle
valid_i  input  1  sym_i qualifier (encoder valid)
sym_i  input  W  encoded symbol in
valid_o  output  1  registered valid_i
sym_o  output  W  sym_i XOR err_mask_o, registered
err_mask_o  output  W  mask applied to the symbol currently on sym_o
burst_active_o  output  1  high while FSM is in BURST
err_bit_ct_o  output  32  total flipped bits since reset, saturating
err_sym_ct_o  output  32  total symbols with nonzero mask since reset, saturating

Behaviour:
- Reset (synchronous, rst=1 at posedge): valid_o=0, sym_o=0, err_mask_o=0, burst_active_o=0, both counters=0, LFSR=SEED, FSM=IDLE, burst count=0. Reset overrides everything, including a burst in progress.
- Latency: exactly 1 cycle, valid_i to valid_o. If valid_i=0: valid_o=0; sym_o and err_mask_o hold; LFSR, FSM and counters hold.
- LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1. Advances once per valid_i cycle. Trigger and mask use the pre-advance value L.
- Raw mask: rm = L[31:32-W] (for W>16, replicate). Forced mask: fm = rm, or all-ones when rm==0.
- FSM states IDLE and BURST, evaluated only on valid_i cycles:
  - mode 0: mask=0; FSM to IDLE.
  - mode 1: if L[N-1:0]=='1 then mask=rm (may be 0, giving no error), else 0; FSM stays IDLE.
  - mode 2, IDLE: if trigger, mask=fm, load burst count with BURST_LEN-1, go to BURST (stay IDLE if BURST_LEN=1); else mask=0.
  - mode 2, BURST: mask=fm and decrement the count. When the count is 0 at this symbol, return to IDLE after it. A burst therefore corrupts exactly BURST_LEN valid symbols.
  - mode 3: mask='1 every symbol; FSM to IDLE.
  - Mode change while in BURST: the new mode applies on that symbol, and the FSM aborts to IDLE.
- burst_active_o is registered alongside sym_o. It is high for the symbols on sym_o that were produced in BURST state or that started a burst.
- Counters update on valid_i cycles: err_bit_ct += popcount(mask); err_sym_ct += (mask!=0). Both saturate at 32'hFFFF_FFFF with no wrap.
- Deterministic: the same SEED and the same valid/mode/sym sequence give an identical output sequence.

Optional Feature:
Macro CHANNEL_ERR_STATS_EN.
- Defined: counters behave as specified.
- Undefined: no counter registers are built; err_bit_ct_o and err_sym_ct_o are tied to 0. All other behaviour is unchanged.

Decomposition:
- Package viterbi_chan_pkg: mode enum (CH_CLEAN, CH_RANDOM, CH_BURST, CH_INVERT), FSM state enum, LFSR polynomial constant, default SEED.
- One sub-module, chan_lfsr32: seed parameter, advance enable, state output, synchronous reset to seed.
- Popcount and saturation logic stay inline in viterbi_burst_channel.

Test Plan:
- mode 0, W=2, 100 valid symbols of random data -> sym_o equals sym_i one cycle later; err_mask_o=0; both counters 0.
- mode 3, W=2, 10 valid symbols of 2'b01 -> sym_o=2'b10 each; err_bit_ct_o=20; err_sym_ct_o=10.
- mode 2, N=1, BURST_LEN=4, valid every cycle until the first trigger -> burst_active_o high for exactly 4 valid outputs; each err_mask_o nonzero; err_sym_ct_o=4 at burst end.
- Burst with valid_i held low for 3 cycles mid-burst -> outputs hold; the burst still covers exactly 4 valid symbols; LFSR does not advance in the gap.
- rst=1 for one cycle during a burst -> next cycle valid_o=0, burst_active_o=0, counters 0; rerunning the same stimulus reproduces an identical mask sequence.
- Counters preloaded near saturation (force) in mode 3 -> err_bit_ct_o stops at 32'hFFFF_FFFF and does not wrap.

Source files
------------

// File: rtl/viterbi_chan_pkg.sv
// rtl/viterbi_chan_pkg.sv - shared types and constants for the Viterbi test-harness channel model
package viterbi_chan_pkg;

    typedef enum logic [1:0] {
        CH_CLEAN  = 2'd0,
        CH_RANDOM = 2'd1,
        CH_BURST  = 2'd2,
        CH_INVERT = 2'd3
    } ch_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } ch_state_e;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2B3D;

endpackage

// File: rtl/chan_lfsr32.sv
// rtl/chan_lfsr32.sv - 32-bit Galois LFSR with enable and synchronous reset to a seed
module chan_lfsr32 import viterbi_chan_pkg::*; #(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    output logic [31:0] o_state
);

    logic [31:0] r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else if (i_en) begin
            r_state <= {1'b0, r_state[31:1]} ^ (r_state[0] ? LFSR_POLY : 32'h0);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/viterbi_burst_channel.sv
// rtl/viterbi_burst_channel.sv - seedable error-injecting channel; CHANNEL_ERR_STATS_EN builds the error counters
module viterbi_burst_channel import viterbi_chan_pkg::*; #(
    parameter int unsigned W         = 2,
    parameter int unsigned N         = 6,
    parameter int unsigned BURST_LEN = 4,
    parameter logic [31:0] SEED      = DEFAULT_SEED
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   mode_i,
    input  logic         valid_i,
    input  logic [W-1:0] sym_i,
    output logic         valid_o,
    output logic [W-1:0] sym_o,
    output logic [W-1:0] err_mask_o,
    output logic         burst_active_o,
    output logic [31:0]  err_bit_ct_o,
    output logic [31:0]  err_sym_ct_o
);

    localparam logic [7:0] BURST_LOAD = 8'(BURST_LEN - 1);

    logic [31:0]  w_lfsr;
    logic         w_trig;
    logic [W-1:0] w_rm;
    logic [W-1:0] w_fm;
    logic [W-1:0] w_mask;
    logic         w_ba;
    ch_mode_e     w_mode;
    ch_state_e    w_state_nxt;
    logic [7:0]   w_cnt_nxt;
    logic         w_unused_lfsr;

    ch_state_e    r_state;
    logic [7:0]   r_cnt;
    logic         r_valid;
    logic [W-1:0] r_sym;
    logic [W-1:0] r_mask;
    logic         r_ba;

    chan_lfsr32 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_en    (valid_i),
        .o_state (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr;
    assign w_trig        = &w_lfsr[N-1:0];
    assign w_rm          = w_lfsr[31 -: W];
    assign w_fm          = (w_rm == '0) ? {W{1'b1}} : w_rm;
    assign w_mode        = ch_mode_e'(mode_i);

    // Any mode other than BURST aborts a running burst on the same symbol
    always_comb begin
        w_mask      = '0;
        w_ba        = 1'b0;
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        case (w_mode)
            CH_CLEAN: begin
                w_mask = '0;
            end
            CH_RANDOM: begin
                if (w_trig) w_mask = w_rm;
            end
            CH_BURST: begin
                if (r_state == ST_BURST) begin
                    w_mask      = w_fm;
                    w_ba        = 1'b1;
                    w_cnt_nxt   = r_cnt - 8'd1;
                    w_state_nxt = (r_cnt == 8'd1) ? ST_IDLE : ST_BURST;
                end else if (w_trig) begin
                    w_mask      = w_fm;
                    w_ba        = 1'b1;
                    w_cnt_nxt   = BURST_LOAD;
                    w_state_nxt = (BURST_LEN > 1) ? ST_BURST : ST_IDLE;
                end
            end
            CH_INVERT: begin
                w_mask = {W{1'b1}};
            end
            default: begin
                w_mask = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_sym   <= '0;
            r_mask  <= '0;
            r_ba    <= 1'b0;
        end else if (valid_i) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= 1'b1;
            r_sym   <= sym_i ^ w_mask;
            r_mask  <= w_mask;
            r_ba    <= w_ba;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign valid_o        = r_valid;
    assign sym_o          = r_sym;
    assign err_mask_o     = r_mask;
    assign burst_active_o = r_ba;

`ifdef CHANNEL_ERR_STATS_EN
    logic [31:0] r_err_bit_ct;
    logic [31:0] r_err_sym_ct;
    logic [5:0]  w_pop;
    logic [32:0] w_bit_sum;
    logic [32:0] w_sym_sum;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < W; i++) begin
            w_pop = w_pop + 6'(w_mask[i]);
        end
        w_bit_sum = {1'b0, r_err_bit_ct} + 33'(w_pop);
        w_sym_sum = {1'b0, r_err_sym_ct} + 33'(|w_mask);
    end

    // Carry out of the 33-bit sum pins the count at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_bit_ct <= '0;
            r_err_sym_ct <= '0;
        end else if (valid_i) begin
            r_err_bit_ct <= w_bit_sum[32] ? 32'hFFFF_FFFF : w_bit_sum[31:0];
            r_err_sym_ct <= w_sym_sum[32] ? 32'hFFFF_FFFF : w_sym_sum[31:0];
        end
    end

    assign err_bit_ct_o = r_err_bit_ct;
    assign err_sym_ct_o = r_err_sym_ct;
`else
    assign err_bit_ct_o = '0;
    assign err_sym_ct_o = '0;
`endif

endmodule

// File: tb/tb_viterbi_burst_channel.sv
// tb/tb_viterbi_burst_channel.sv - randomized self-checking bench for viterbi_burst_channel
module tb_viterbi_burst_channel;

    localparam int W  = 2;
    localparam int N  = 1;
    localparam int BL = 4;
    localparam logic [31:0] SEED = 32'hACE1_2B3D;
`ifdef CHANNEL_ERR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   mode_i = 2'd0;
    logic         valid_i = 1'b0;
    logic [W-1:0] sym_i = '0;
    logic         valid_o;
    logic [W-1:0] sym_o;
    logic [W-1:0] err_mask_o;
    logic         burst_active_o;
    logic [31:0]  err_bit_ct_o;
    logic [31:0]  err_sym_ct_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: LFSR value, symbols left in the current burst, expected outputs
    logic [31:0]  m_l;
    int           m_rem;
    logic         e_valid;
    logic [W-1:0] e_sym;
    logic [W-1:0] e_mask;
    logic         e_ba;
    logic [31:0]  e_bits;
    logic [31:0]  e_syms;

    viterbi_burst_channel #(.W(W), .N(N), .BURST_LEN(BL), .SEED(SEED)) dut (
        .clk            (clk),
        .rst            (rst),
        .mode_i         (mode_i),
        .valid_i        (valid_i),
        .sym_i          (sym_i),
        .valid_o        (valid_o),
        .sym_o          (sym_o),
        .err_mask_o     (err_mask_o),
        .burst_active_o (burst_active_o),
        .err_bit_ct_o   (err_bit_ct_o),
        .err_sym_ct_o   (err_sym_ct_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic model_reset();
        m_l = SEED; m_rem = 0;
        e_valid = 0; e_sym = '0; e_mask = '0; e_ba = 0; e_bits = '0; e_syms = '0;
    endtask

    task automatic model_valid(input logic [1:0] m, input logic [W-1:0] s);
        logic [W-1:0] rm, fm, mk;
        logic trig;
        longint pop;
        trig = (m_l[N-1:0] == {N{1'b1}});
        rm   = m_l[31 -: W];
        fm   = (rm == '0) ? {W{1'b1}} : rm;
        mk   = '0;
        e_ba = 1'b0;
        case (m)
            2'd0: m_rem = 0;
            2'd1: begin if (trig) mk = rm; m_rem = 0; end
            2'd2: begin
                if (m_rem > 0) begin mk = fm; e_ba = 1; m_rem--; end
                else if (trig) begin mk = fm; e_ba = 1; m_rem = BL - 1; end
            end
            default: begin mk = {W{1'b1}}; m_rem = 0; end
        endcase
        e_valid = 1'b1;
        e_mask  = mk;
        e_sym   = s ^ mk;
        if (STATS) begin
            pop    = longint'($countones(mk));
            e_bits = (longint'(e_bits) + pop > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : e_bits + 32'(pop);
            e_syms = (mk != '0 && e_syms == 32'hFFFF_FFFF) ? e_syms : e_syms + 32'(mk != '0);
        end
        m_l = lfsr_next(m_l);
    endtask

    task automatic cycle(input logic v, input logic [1:0] m, input logic [W-1:0] s);
        @(negedge clk);
        rst = 0; valid_i = v; mode_i = m; sym_i = s;
        if (v) model_valid(m, s);
        else   e_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; valid_i = 0; mode_i = 0; sym_i = '0;
        model_reset();
        @(posedge clk); #1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp += 6;
        if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", valid_o); end
        if (sym_o !== '0) begin n_bad++; $display("FAIL reset_sym got %0h want 0", sym_o); end
        if (err_mask_o !== '0) begin n_bad++; $display("FAIL reset_mask got %0h want 0", err_mask_o); end
        if (burst_active_o !== 1'b0) begin n_bad++; $display("FAIL reset_burst got %0b want 0", burst_active_o); end
        if (err_bit_ct_o !== 32'h0) begin n_bad++; $display("FAIL reset_bitct got %0h want 0", err_bit_ct_o); end
        if (err_sym_ct_o !== 32'h0) begin n_bad++; $display("FAIL reset_symct got %0h want 0", err_sym_ct_o); end
    endtask

    task automatic test_clean();
        logic [W-1:0] s;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            s = W'($urandom);
            cycle(1, 2'd0, s);
            n_cmp += 3;
            if (valid_o !== 1'b1) begin n_bad++; $display("FAIL clean_valid i=%0d got %0b want 1", i, valid_o); end
            if (sym_o !== s) begin n_bad++; $display("FAIL clean_sym i=%0d got %0h want %0h", i, sym_o, s); end
            if (err_mask_o !== '0) begin n_bad++; $display("FAIL clean_mask i=%0d got %0h want 0", i, err_mask_o); end
        end
        n_cmp += 2;
        if (err_bit_ct_o !== 32'h0) begin n_bad++; $display("FAIL clean_bitct got %0d want 0", err_bit_ct_o); end
        if (err_sym_ct_o !== 32'h0) begin n_bad++; $display("FAIL clean_symct got %0d want 0", err_sym_ct_o); end
    endtask

    task automatic test_invert();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1, 2'd3, 2'b01);
            n_cmp += 2;
            if (sym_o !== 2'b10) begin n_bad++; $display("FAIL invert_sym i=%0d got %0h want 2", i, sym_o); end
            if (err_mask_o !== 2'b11) begin n_bad++; $display("FAIL invert_mask i=%0d got %0h want 3", i, err_mask_o); end
        end
        n_cmp += 2;
        if (err_bit_ct_o !== (STATS ? 32'd20 : 32'd0)) begin n_bad++; $display("FAIL invert_bitct got %0d want %0d", err_bit_ct_o, STATS ? 20 : 0); end
        if (err_sym_ct_o !== (STATS ? 32'd10 : 32'd0)) begin n_bad++; $display("FAIL invert_symct got %0d want %0d", err_sym_ct_o, STATS ? 10 : 0); end
    endtask

    task automatic test_burst();
        int guard = 0;
        do_reset();
        do begin
            cycle(1, 2'd2, W'($urandom));
            guard++;
        end while (!e_ba && guard < 200);
        n_cmp++;
        if (!e_ba) begin n_bad++; $display("FAIL burst_start no trigger within %0d symbols", guard); end
        for (int i = 0; i < BL; i++) begin
            if (i > 0) cycle(1, 2'd2, W'($urandom));
            n_cmp += 3;
            if (burst_active_o !== 1'b1) begin n_bad++; $display("FAIL burst_active i=%0d got %0b want 1", i, burst_active_o); end
            if (err_mask_o === '0) begin n_bad++; $display("FAIL burst_mask_zero i=%0d got 0 want nonzero", i); end
            if (err_mask_o !== e_mask) begin n_bad++; $display("FAIL burst_mask i=%0d got %0h want %0h", i, err_mask_o, e_mask); end
        end
        n_cmp++;
        if (err_sym_ct_o !== (STATS ? 32'd4 : 32'd0)) begin n_bad++; $display("FAIL burst_symct got %0d want %0d", err_sym_ct_o, STATS ? 4 : 0); end
        cycle(1, 2'd0, '0);
        n_cmp++;
        if (burst_active_o !== 1'b0) begin n_bad++; $display("FAIL burst_end got %0b want 0", burst_active_o); end
    endtask

    task automatic test_burst_gap();
        int guard = 0;
        do_reset();
        do begin
            cycle(1, 2'd2, W'($urandom));
            guard++;
        end while (!e_ba && guard < 200);
        cycle(1, 2'd2, W'($urandom));
        for (int i = 0; i < 3; i++) begin
            cycle(0, 2'd2, W'($urandom));
            n_cmp += 4;
            if (valid_o !== 1'b0) begin n_bad++; $display("FAIL gap_valid i=%0d got %0b want 0", i, valid_o); end
            if (sym_o !== e_sym) begin n_bad++; $display("FAIL gap_sym i=%0d got %0h want %0h", i, sym_o, e_sym); end
            if (err_mask_o !== e_mask) begin n_bad++; $display("FAIL gap_mask i=%0d got %0h want %0h", i, err_mask_o, e_mask); end
            if (burst_active_o !== 1'b1) begin n_bad++; $display("FAIL gap_burst i=%0d got %0b want 1", i, burst_active_o); end
        end
        for (int i = 0; i < 2; i++) begin
            cycle(1, 2'd2, W'($urandom));
            n_cmp += 3;
            if (burst_active_o !== 1'b1) begin n_bad++; $display("FAIL gap_tail_burst i=%0d got %0b want 1", i, burst_active_o); end
            if (err_mask_o !== e_mask) begin n_bad++; $display("FAIL gap_tail_mask i=%0d got %0h want %0h", i, err_mask_o, e_mask); end
            if (sym_o !== e_sym) begin n_bad++; $display("FAIL gap_tail_sym i=%0d got %0h want %0h", i, sym_o, e_sym); end
        end
        cycle(1, 2'd0, '0);
        n_cmp += 2;
        if (burst_active_o !== 1'b0) begin n_bad++; $display("FAIL gap_end got %0b want 0", burst_active_o); end
        if (err_sym_ct_o !== e_syms) begin n_bad++; $display("FAIL gap_symct got %0d want %0d", err_sym_ct_o, e_syms); end
    endtask

    task automatic test_reset_mid_burst();
        logic         sv [40];
        logic [1:0]   sm [40];
        logic [W-1:0] ss [40];
        int guard = 0;
        do_reset();
        do begin
            cycle(1, 2'd2, W'($urandom));
            guard++;
        end while (!e_ba && guard < 200);
        cycle(1, 2'd2, W'($urandom));
        @(negedge clk);
        rst = 1; valid_i = 1; mode_i = 2'd2;
        model_reset();
        @(posedge clk); #1;
        n_cmp += 4;
        if (valid_o !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %0b want 0", valid_o); end
        if (burst_active_o !== 1'b0) begin n_bad++; $display("FAIL midrst_burst got %0b want 0", burst_active_o); end
        if (err_bit_ct_o !== 32'h0) begin n_bad++; $display("FAIL midrst_bitct got %0d want 0", err_bit_ct_o); end
        if (err_sym_ct_o !== 32'h0) begin n_bad++; $display("FAIL midrst_symct got %0d want 0", err_sym_ct_o); end
        for (int i = 0; i < 40; i++) begin
            sv[i] = ($urandom_range(0, 3) != 0);
            sm[i] = 2'($urandom_range(1, 2));
            ss[i] = W'($urandom);
        end
        for (int rep = 0; rep < 2; rep++) begin
            do_reset();
            for (int i = 0; i < 40; i++) begin
                cycle(sv[i], sm[i], ss[i]);
                n_cmp += 3;
                if (err_mask_o !== e_mask) begin n_bad++; $display("FAIL replay_mask rep=%0d i=%0d got %0h want %0h", rep, i, err_mask_o, e_mask); end
                if (sym_o !== e_sym) begin n_bad++; $display("FAIL replay_sym rep=%0d i=%0d got %0h want %0h", rep, i, sym_o, e_sym); end
                if (burst_active_o !== e_ba) begin n_bad++; $display("FAIL replay_burst rep=%0d i=%0d got %0b want %0b", rep, i, burst_active_o, e_ba); end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), W'($urandom));
            n_cmp += 6;
            if (valid_o !== e_valid) begin n_bad++; $display("FAIL rand_valid i=%0d got %0b want %0b", i, valid_o, e_valid); end
            if (sym_o !== e_sym) begin n_bad++; $display("FAIL rand_sym i=%0d got %0h want %0h", i, sym_o, e_sym); end
            if (err_mask_o !== e_mask) begin n_bad++; $display("FAIL rand_mask i=%0d got %0h want %0h", i, err_mask_o, e_mask); end
            if (burst_active_o !== e_ba) begin n_bad++; $display("FAIL rand_burst i=%0d got %0b want %0b", i, burst_active_o, e_ba); end
            if (err_bit_ct_o !== e_bits) begin n_bad++; $display("FAIL rand_bitct i=%0d got %0d want %0d", i, err_bit_ct_o, e_bits); end
            if (err_sym_ct_o !== e_syms) begin n_bad++; $display("FAIL rand_symct i=%0d got %0d want %0d", i, err_sym_ct_o, e_syms); end
        end
    endtask

`ifdef CHANNEL_ERR_STATS_EN
    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        force dut.r_err_bit_ct = 32'hFFFF_FFF0;
        force dut.r_err_sym_ct = 32'hFFFF_FFFC;
        #1;
        release dut.r_err_bit_ct;
        release dut.r_err_sym_ct;
        e_bits = 32'hFFFF_FFF0;
        e_syms = 32'hFFFF_FFFC;
        for (int i = 0; i < 10; i++) begin
            cycle(1, 2'd3, W'($urandom));
            n_cmp += 2;
            if (err_bit_ct_o !== e_bits) begin n_bad++; $display("FAIL sat_bitct i=%0d got %0h want %0h", i, err_bit_ct_o, e_bits); end
            if (err_sym_ct_o !== e_syms) begin n_bad++; $display("FAIL sat_symct i=%0d got %0h want %0h", i, err_sym_ct_o, e_syms); end
        end
        n_cmp += 2;
        if (err_bit_ct_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat_bit_final got %0h want ffffffff", err_bit_ct_o); end
        if (err_sym_ct_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat_sym_final got %0h want ffffffff", err_sym_ct_o); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_clean();
        test_invert();
        test_burst();
        test_burst_gap();
        test_reset_mid_burst();
        test_random();
`ifdef CHANNEL_ERR_STATS_EN
        test_saturation();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
